// File: rtl/pulse_stretch_fsm_if.sv
// Signal bundle between a strobe source and pulse_stretch_fsm.
// The stretcher takes the slave side; whatever drives tick takes the master side.
interface pulse_stretch_fsm_if;
  logic       tick;
  logic       level;
  logic       busy;
  logic       dropped;
  logic [7:0] drop_cnt;

  modport master (
    output tick,
    input  level,
    input  busy,
    input  dropped,
    input  drop_cnt
  );

  modport slave (
    input  tick,
    output level,
    output busy,
    output dropped,
    output drop_cnt
  );
endinterface

// File: rtl/pulse_stretch_fsm.sv
// Stretches single-cycle ticks into fixed-width level pulses with an enforced low gap.
// Define PULSE_STRETCH_RETRIGGER_EN to let ticks during the high phase extend the pulse.
module pulse_stretch_fsm #(
  parameter int HIGH_CYCLES = 4,
  parameter int GAP_CYCLES  = 2
) (
  input  logic                clk,
  input  logic                reset,
  pulse_stretch_fsm_if.slave  bus
);

  localparam int MAX_CYCLES = (HIGH_CYCLES > GAP_CYCLES) ? HIGH_CYCLES : GAP_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES + 1);

  localparam logic [CW-1:0] HIGH_LOAD = CW'(HIGH_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = (GAP_CYCLES > 0) ? CW'(GAP_CYCLES - 1) : '0;
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          dropped_q, dropped_d;
  logic [7:0]    drop_cnt_q, drop_cnt_d;
  logic          reject;

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      dropped_q  <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dropped_q  <= dropped_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = ST_IDLE;
    cnt_d   = '0;
    reject  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.tick) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = cnt_q;
        end
      end

      ST_HIGH: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (bus.tick) begin
          state_d = ST_HIGH;
          cnt_d   = HIGH_LOAD;
        end else
`else
        reject = bus.tick;
`endif
        if (cnt_q != '0) begin
          state_d = ST_HIGH;
          cnt_d   = cnt_q - CNT_ONE;
        end else if (GAP_CYCLES > 0) begin
          state_d = ST_GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      ST_GAP: begin
        reject = bus.tick;
        if (cnt_q != '0) begin
          state_d = ST_GAP;
          cnt_d   = cnt_q - CNT_ONE;
        end else begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      end

      default: begin
        // Unreachable encoding: recover to IDLE on the next edge.
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase

    dropped_d  = reject;
    drop_cnt_d = (reject && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  // Moore outputs decoded from the registered state
  always_comb begin
    bus.level = 1'b0;
    bus.busy  = 1'b0;
    case (state_q)
      ST_HIGH: begin
        bus.level = 1'b1;
        bus.busy  = 1'b1;
      end
      ST_GAP: begin
        bus.busy  = 1'b1;
      end
      default: begin
        bus.level = 1'b0;
        bus.busy  = 1'b0;
      end
    endcase
  end

  assign bus.dropped  = dropped_q;
  assign bus.drop_cnt = drop_cnt_q;

endmodule
